// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion,
// flush/hold control and a saturating load-use stall counter.
module id_ex_stage #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset_n,
  input  logic              ID_valid,
  input  logic [4:0]        ID_rs,
  input  logic [4:0]        ID_rt,
  input  logic              ID_uses_rt,
  input  logic [4:0]        ID_dest,
  input  logic [31:0]       ID_rs_data,
  input  logic [31:0]       ID_rt_data,
  input  logic [31:0]       ID_imm,
  input  logic [CTRL_W-1:0] ID_ctrl,
  input  logic              WB_write,
  input  logic [4:0]        WB_addr,
  input  logic [31:0]       WB_data,
  input  logic              EX_flush,
  input  logic              EX_hold,
  output logic              ID_stall,
  output logic              EX_valid,
  output logic [4:0]        EX_rs,
  output logic [4:0]        EX_rt,
  output logic [4:0]        EX_dest,
  output logic [31:0]       EX_rs_data,
  output logic [31:0]       EX_rt_data,
  output logic [31:0]       EX_imm,
  output logic [CTRL_W-1:0] EX_ctrl,
  output logic [CNT_W-1:0]  STALL_cnt
);

  localparam int unsigned MemReadBit = 1;

  logic              valid_q,   valid_d;
  logic [4:0]        rs_q,      rs_d;
  logic [4:0]        rt_q,      rt_d;
  logic [4:0]        dest_q,    dest_d;
  logic [31:0]       rs_data_q, rs_data_d;
  logic [31:0]       rt_data_q, rt_data_d;
  logic [31:0]       imm_q,     imm_d;
  logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  logic [31:0] rs_sel;
  logic [31:0] rt_sel;
  logic        haz;

  // The register file writes on the same edge it is read for, so forward WB here.
  always_comb begin
    rs_sel = ID_rs_data;
    if (ID_rs == 5'd0) begin
      rs_sel = 32'd0;
    end else if (WB_write && (WB_addr == ID_rs)) begin
      rs_sel = WB_data;
    end
  end

  always_comb begin
    rt_sel = ID_rt_data;
    if (ID_rt == 5'd0) begin
      rt_sel = 32'd0;
    end else if (WB_write && (WB_addr == ID_rt)) begin
      rt_sel = WB_data;
    end
  end

  always_comb begin
    haz = ID_valid && valid_q && ctrl_q[MemReadBit] && (dest_q != 5'd0) &&
          ((dest_q == ID_rs) || (ID_uses_rt && (dest_q == ID_rt)));
  end

  // Gated by reset so upstream is never held while the pipe is being cleared.
  always_comb begin
    ID_stall = SYS_reset_n && !EX_flush && (EX_hold || haz);
  end

  always_comb begin
    valid_d   = valid_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    dest_d    = dest_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    ctrl_d    = ctrl_q;
    cnt_d     = cnt_q;
    if (EX_flush || (!EX_hold && haz)) begin
      valid_d   = 1'b0;
      rs_d      = 5'd0;
      rt_d      = 5'd0;
      dest_d    = 5'd0;
      rs_data_d = 32'd0;
      rt_data_d = 32'd0;
      imm_d     = 32'd0;
      ctrl_d    = '0;
      // Only a real bubble counts; a flush in the same cycle supersedes it.
      if (!EX_flush && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!EX_hold) begin
      valid_d   = ID_valid;
      rs_d      = ID_rs;
      rt_d      = ID_rt;
      dest_d    = ID_dest;
      rs_data_d = rs_sel;
      rt_data_d = rt_sel;
      imm_d     = ID_imm;
      ctrl_d    = ID_valid ? ID_ctrl : '0;
    end
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      valid_q   <= 1'b0;
      rs_q      <= 5'd0;
      rt_q      <= 5'd0;
      dest_q    <= 5'd0;
      rs_data_q <= 32'd0;
      rt_data_q <= 32'd0;
      imm_q     <= 32'd0;
      ctrl_q    <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      dest_q    <= dest_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
    end
  end

  assign EX_valid   = valid_q;
  assign EX_rs      = rs_q;
  assign EX_rt      = rt_q;
  assign EX_dest    = dest_q;
  assign EX_rs_data = rs_data_q;
  assign EX_rt_data = rt_data_q;
  assign EX_imm     = imm_q;
  assign EX_ctrl    = ctrl_q;
  assign STALL_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed cycle table, async reset and counter saturation
// sequences, then randomized traffic against a behavioural model.
module tb_id_ex_stage;

  localparam int unsigned CtrlW = 8;
  localparam int unsigned CntW  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid = 1'b0;
  logic [4:0]       id_rs = '0, id_rt = '0, id_dest = '0;
  logic             id_uses_rt = 1'b0;
  logic [31:0]      id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [CtrlW-1:0] id_ctrl = '0;
  logic             wb_write = 1'b0;
  logic [4:0]       wb_addr = '0;
  logic [31:0]      wb_data = '0;
  logic             ex_flush = 1'b0, ex_hold = 1'b0;
  logic             id_stall, ex_valid;
  logic [4:0]       ex_rs, ex_rt, ex_dest;
  logic [31:0]      ex_rs_data, ex_rt_data, ex_imm;
  logic [CtrlW-1:0] ex_ctrl;
  logic [CntW-1:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  id_ex_stage #(.CTRL_W(CtrlW), .CNT_W(CntW)) dut (
    .SYS_clk(clk), .SYS_reset_n(rst_n),
    .ID_valid(id_valid), .ID_rs(id_rs), .ID_rt(id_rt), .ID_uses_rt(id_uses_rt),
    .ID_dest(id_dest), .ID_rs_data(id_rs_data), .ID_rt_data(id_rt_data),
    .ID_imm(id_imm), .ID_ctrl(id_ctrl),
    .WB_write(wb_write), .WB_addr(wb_addr), .WB_data(wb_data),
    .EX_flush(ex_flush), .EX_hold(ex_hold), .ID_stall(id_stall),
    .EX_valid(ex_valid), .EX_rs(ex_rs), .EX_rt(ex_rt), .EX_dest(ex_dest),
    .EX_rs_data(ex_rs_data), .EX_rt_data(ex_rt_data), .EX_imm(ex_imm),
    .EX_ctrl(ex_ctrl), .STALL_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        uses_rt;
    logic [4:0]  dest;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [7:0]  ctrl;
    logic        wb;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        hold;
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_rs_data;
    logic [31:0] e_rt_data;
    logic [7:0]  e_ctrl;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl[15];

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic u, input logic [4:0] d, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [7:0] c);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = u; id_dest = d;
    id_rs_data = rsd; id_rt_data = rtd; id_ctrl = c;
  endtask

  // Behavioural model of the EX register contents.
  logic        m_valid;
  logic [4:0]  m_rs, m_rt, m_dest;
  logic [31:0] m_rs_data, m_rt_data, m_imm;
  logic [7:0]  m_ctrl;
  int          m_cnt;

  function automatic logic [31:0] pick(input logic [4:0] a, input logic [31:0] d);
    if (a == 0) return 32'd0;
    if (wb_write && wb_addr == a) return wb_data;
    return d;
  endfunction

  function automatic logic model_haz();
    if (!id_valid || !m_valid || !m_ctrl[1] || m_dest == 0) return 1'b0;
    return (m_dest == id_rs) || (id_uses_rt && m_dest == id_rt);
  endfunction

  task automatic model_clear();
    m_valid = 0; m_rs = 0; m_rt = 0; m_dest = 0;
    m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_ctrl = 0;
  endtask

  initial begin
    tbl[0]  = '{1,10,0,1,3,13,7,8'h01,1,10,99,0,0, 0,1,99,0,8'h01,0};
    tbl[1]  = '{1,0,4,1,5,5,44,8'h01,1,0,77,0,0, 0,1,0,44,8'h01,0};
    tbl[2]  = '{1,2,6,0,11,20,30,8'h83,0,0,0,0,0, 0,1,20,30,8'h83,0};
    tbl[3]  = '{1,11,12,1,13,50,60,8'h01,0,0,0,0,0, 1,0,0,0,8'h00,1};
    tbl[4]  = '{1,11,12,1,13,50,60,8'h01,0,0,0,0,0, 0,1,50,60,8'h01,1};
    tbl[5]  = '{1,1,0,0,11,8,9,8'h02,0,0,0,0,0, 0,1,8,0,8'h02,1};
    tbl[6]  = '{1,3,11,0,14,1,2,8'h01,0,0,0,0,0, 0,1,1,2,8'h01,1};
    tbl[7]  = '{1,1,0,0,11,8,9,8'h02,0,0,0,0,0, 0,1,8,0,8'h02,1};
    tbl[8]  = '{1,11,0,1,15,4,5,8'h01,0,0,0,1,0, 0,0,0,0,8'h00,1};
    tbl[9]  = '{0,7,0,1,11,32'h33,9,8'hFF,0,0,0,0,0, 0,0,32'h33,0,8'h00,1};
    tbl[10] = '{1,9,0,0,12,18,0,8'h01,0,0,0,0,0, 0,1,18,0,8'h01,1};
    tbl[11] = '{1,9,0,0,12,18,0,8'h01,1,9,21,0,1, 1,1,18,0,8'h01,1};
    tbl[12] = '{1,9,0,0,12,21,0,8'h01,0,0,0,0,1, 1,1,18,0,8'h01,1};
    tbl[13] = '{1,9,0,0,12,21,0,8'h01,0,0,0,0,1, 1,1,18,0,8'h01,1};
    tbl[14] = '{1,9,0,0,12,21,0,8'h01,0,0,0,0,0, 0,1,21,0,8'h01,1};

    #12;
    check("reset_valid", {31'd0, ex_valid}, 32'd0);
    check("reset_cnt", {28'd0, stall_cnt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].valid, tbl[i].rs, tbl[i].rt, tbl[i].uses_rt, tbl[i].dest,
            tbl[i].rs_data, tbl[i].rt_data, tbl[i].ctrl);
      id_imm = 32'h1000 + i;
      wb_write = tbl[i].wb; wb_addr = tbl[i].wb_addr; wb_data = tbl[i].wb_data;
      ex_flush = tbl[i].flush; ex_hold = tbl[i].hold;
      #2;
      check($sformatf("tbl%0d_stall", i), {31'd0, id_stall}, {31'd0, tbl[i].e_stall});
      @(posedge clk); #1;
      check($sformatf("tbl%0d_valid", i), {31'd0, ex_valid}, {31'd0, tbl[i].e_valid});
      check($sformatf("tbl%0d_rs_data", i), ex_rs_data, tbl[i].e_rs_data);
      check($sformatf("tbl%0d_rt_data", i), ex_rt_data, tbl[i].e_rt_data);
      check($sformatf("tbl%0d_ctrl", i), {24'd0, ex_ctrl}, {24'd0, tbl[i].e_ctrl});
      check($sformatf("tbl%0d_cnt", i), {28'd0, stall_cnt}, {28'd0, tbl[i].e_cnt});
    end

    // Asynchronous reset mid-cycle with a valid instruction in EX and hold asserted.
    ex_hold = 1'b1; wb_write = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", {31'd0, ex_valid}, 32'd0);
    check("async_rs_data", ex_rs_data, 32'd0);
    check("async_imm", ex_imm, 32'd0);
    check("async_ctrl", {24'd0, ex_ctrl}, 32'd0);
    check("async_dest", {27'd0, ex_dest}, 32'd0);
    check("async_cnt", {28'd0, stall_cnt}, 32'd0);
    check("async_stall", {31'd0, id_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; ex_hold = 1'b0;
    @(posedge clk); #1;

    // Saturation: 2^CntW + 2 load-use bubbles.
    for (int i = 0; i < (1 << CntW) + 2; i++) begin
      drive(1, 1, 0, 0, 11, 8, 9, 8'h02);
      @(posedge clk); #1;
      drive(1, 11, 0, 1, 12, 3, 4, 8'h01);
      @(posedge clk); #1;
      if (i == 0) check("sat_first", {28'd0, stall_cnt}, 32'd1);
      if (i == 14) check("sat_reach", {28'd0, stall_cnt}, 32'd15);
    end
    check("sat_hold", {28'd0, stall_cnt}, 32'd15);

    // Randomized traffic against the model, starting from a fresh reset.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_clear();
    m_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      logic exp_stall, haz;
      drive(1'($urandom_range(0, 4) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom_range(0, 3)), $urandom, $urandom, 8'($urandom));
      id_imm = $urandom;
      wb_write = 1'($urandom); wb_addr = 5'($urandom_range(0, 3)); wb_data = $urandom;
      ex_flush = ($urandom_range(0, 7) == 0);
      ex_hold = ($urandom_range(0, 5) == 0);
      haz = model_haz();
      exp_stall = !ex_flush && (ex_hold || haz);
      #2;
      check("rnd_stall", {31'd0, id_stall}, {31'd0, exp_stall});
      if (ex_flush) begin
        model_clear();
      end else if (ex_hold) begin
        // EX contents stay put
      end else if (haz) begin
        model_clear();
        if (m_cnt < (1 << CntW) - 1) m_cnt++;
      end else begin
        m_valid = id_valid; m_rs = id_rs; m_rt = id_rt; m_dest = id_dest;
        m_rs_data = pick(id_rs, id_rs_data); m_rt_data = pick(id_rt, id_rt_data);
        m_imm = id_imm; m_ctrl = id_valid ? id_ctrl : 8'd0;
      end
      @(posedge clk); #1;
      check("rnd_valid", {31'd0, ex_valid}, {31'd0, m_valid});
      check("rnd_rs", {27'd0, ex_rs}, {27'd0, m_rs});
      check("rnd_rt", {27'd0, ex_rt}, {27'd0, m_rt});
      check("rnd_dest", {27'd0, ex_dest}, {27'd0, m_dest});
      check("rnd_rs_data", ex_rs_data, m_rs_data);
      check("rnd_rt_data", ex_rt_data, m_rt_data);
      check("rnd_imm", ex_imm, m_imm);
      check("rnd_ctrl", {24'd0, ex_ctrl}, {24'd0, m_ctrl});
      check("rnd_cnt", {28'd0, stall_cnt}, 32'(m_cnt));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
